probe_capture_buffer: RTL and testbench

//  Parametrised debug probe capture unit with a trigger and a pre-trigger ring buffer.

---
 rtl/probe_capture_buffer.sv | 142 ++++++++++++++
 tb/tb_probe_capture_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/probe_capture_buffer.sv
// Debug probe capture: registered (optionally inverted) probe, masked-compare trigger, pre-trigger ring of DEPTH samples.
// Window streams out oldest-first over ready/valid and holds during stalls; data pass-through is a fixed PIPE_STAGES delay.
module probe_capture_buffer #(
  parameter int                 PROBE_W     = 13,
  parameter logic [PROBE_W-1:0] INV_MASK    = '0,
  parameter int                 DEPTH       = 16,
  parameter int                 PRE_TRIG    = 4,
  parameter int                 DATA_W      = 8,
  parameter int                 PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  input  logic [PROBE_W-1:0] probe_in,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic               arm,
  output logic               busy,
  output logic               triggered,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [PROBE_W-1:0] rd_data,
  output logic               rd_last
);

  localparam int AW       = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam int PRE_LAST = (PRE_TRIG > 0) ? PRE_TRIG - 1 : 0;
  localparam int POST_N   = DEPTH - PRE_TRIG - 1;

  typedef enum logic [2:0] {ST_IDLE, ST_PRE, ST_ARMED, ST_POST, ST_DONE} state_t;

  state_t             state_q, state_d;
  logic [PROBE_W-1:0] probe_q;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      cnt_q, cnt_d;
  logic [AW-1:0]      post_q, post_d;
  logic [AW-1:0]      rd_cnt_q, rd_cnt_d;
  logic               triggered_q, triggered_d;
  logic [PROBE_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0]  pipe_q [PIPE_STAGES];

  logic          hit;
  logic          wr_en;
  logic [AW-1:0] rd_ptr;

  assign hit       = ((probe_q ^ trig_value) & trig_mask) == '0;
  assign busy      = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);
  assign done      = (state_q == ST_DONE);
  assign triggered = triggered_q;
  assign wr_en     = busy && !arm;
  // wr_ptr is frozen in DONE and points at the oldest entry, so reads walk forward from it
  assign rd_ptr    = wr_ptr_q + rd_cnt_q;
  assign rd_valid  = done;
  assign rd_data   = rd_valid ? mem_q[rd_ptr] : '0;
  assign rd_last   = rd_valid && (rd_cnt_q == AW'(DEPTH - 1));
  assign data_out  = pipe_q[PIPE_STAGES-1];

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cnt_d       = cnt_q;
    post_d      = post_q;
    rd_cnt_d    = rd_cnt_q;
    triggered_d = triggered_q;
    if (arm) begin
      // restart from any state, including on the final read transfer
      state_d     = (PRE_TRIG == 0) ? ST_ARMED : ST_PRE;
      wr_ptr_d    = '0;
      cnt_d       = '0;
      post_d      = '0;
      rd_cnt_d    = '0;
      triggered_d = 1'b0;
    end else begin
      case (state_q)
        ST_PRE: begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          cnt_d    = cnt_q + AW'(1);
          if (cnt_q == AW'(PRE_LAST)) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (hit) begin
            triggered_d = 1'b1;
            post_d      = AW'(POST_N);
            state_d     = (POST_N == 0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          post_d   = post_q - AW'(1);
          if (post_q == AW'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (rd_ready) begin
            rd_cnt_d = rd_cnt_q + AW'(1);
            if (rd_cnt_q == AW'(DEPTH - 1)) begin
              rd_cnt_d = '0;
              state_d  = ST_IDLE;
            end
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      probe_q     <= '0;
      wr_ptr_q    <= '0;
      cnt_q       <= '0;
      post_q      <= '0;
      rd_cnt_q    <= '0;
      triggered_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      probe_q     <= probe_in ^ INV_MASK;
      wr_ptr_q    <= wr_ptr_d;
      cnt_q       <= cnt_d;
      post_q      <= post_d;
      rd_cnt_q    <= rd_cnt_d;
      triggered_q <= triggered_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= probe_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PIPE_STAGES; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= data_in;
      for (int i = 1; i < PIPE_STAGES; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

endmodule

// File: tb/tb_probe_capture_buffer.sv
// Directed bench for probe_capture_buffer: one plain instance and one with all probe bits inverted.
module tb_probe_capture_buffer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  data_in;
  logic [7:0]  a_data_out, b_data_out;
  logic [12:0] a_probe, a_tval, a_tmask;
  logic        a_arm, a_rdy;
  logic        a_busy, a_trig, a_done, a_vld, a_last;
  logic [12:0] a_rdata;
  logic        b_arm, b_rdy;
  logic        b_busy, b_trig, b_done, b_vld, b_last;
  logic [12:0] b_rdata;
  logic [12:0] b_probe, b_tval, b_tmask;

  int checks;
  int failures;

  typedef struct {
    logic        rdy;
    logic        vld;
    logic [12:0] dat;
    logic        last;
  } vec_t;

  vec_t tbl[16];

  probe_capture_buffer #(
    .PROBE_W(13), .INV_MASK(13'h0000), .DEPTH(8), .PRE_TRIG(3), .DATA_W(8), .PIPE_STAGES(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(a_data_out),
    .probe_in(a_probe), .trig_value(a_tval), .trig_mask(a_tmask), .arm(a_arm),
    .busy(a_busy), .triggered(a_trig), .done(a_done), .rd_valid(a_vld),
    .rd_ready(a_rdy), .rd_data(a_rdata), .rd_last(a_last)
  );

  probe_capture_buffer #(
    .PROBE_W(13), .INV_MASK(13'h1FFF), .DEPTH(8), .PRE_TRIG(3), .DATA_W(8), .PIPE_STAGES(2)
  ) u_inv (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_out(b_data_out),
    .probe_in(b_probe), .trig_value(b_tval), .trig_mask(b_tmask), .arm(b_arm),
    .busy(b_busy), .triggered(b_trig), .done(b_done), .rd_valid(b_vld),
    .rd_ready(b_rdy), .rd_data(b_rdata), .rd_last(b_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Inputs change just after a falling edge; outputs are checked at the next falling edge.
  task automatic drive(input logic [12:0] p, input logic a, input logic r);
    a_probe = p;
    a_arm   = a;
    a_rdy   = r;
    @(negedge clk);
  endtask

  // Free-running count 0..last_v; arm lands on the edge where probe_q == arm_v-1.
  task automatic run_sched(input int last_v, input int arm_v);
    for (int v = 0; v <= last_v; v++) drive(13'(v), (v == arm_v), 1'b0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    tbl[0]  = '{1'b1, 1'b1, 13'd17, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 13'd18, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 13'd18, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 13'd19, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 13'd19, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 13'd20, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 13'd20, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 13'd21, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 13'd21, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 13'd22, 1'b0};
    tbl[10] = '{1'b1, 1'b1, 13'd22, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 13'd23, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 13'd23, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 13'd24, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 13'd24, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 13'd0,  1'b0};

    rst_n   = 1'b0;
    data_in = '0;
    a_probe = '0; a_tval = '0; a_tmask = 13'h1FFF; a_arm = 1'b0; a_rdy = 1'b0;
    b_probe = '0; b_tval = '0; b_tmask = 13'h0000; b_arm = 1'b0; b_rdy = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, a_busy}, 0);
    chk("reset_trig", {31'd0, a_trig}, 0);
    chk("reset_done", {31'd0, a_done}, 0);
    chk("reset_vld", {31'd0, a_vld}, 0);
    chk("reset_last", {31'd0, a_last}, 0);
    chk("reset_dout", {24'd0, a_data_out}, 0);
    rst_n = 1'b1;
    drive(13'd0, 1'b0, 1'b0);

    // Test 1: count, trigger at 20, window 17..24
    a_tval = 13'd20;
    run_sched(24, 6);
    chk("t1_busy_post", {31'd0, a_busy}, 1);
    chk("t1_done_early", {31'd0, a_done}, 0);
    drive(13'd25, 1'b0, 1'b0);
    chk("t1_done", {31'd0, a_done}, 1);
    chk("t1_busy_done", {31'd0, a_busy}, 0);
    chk("t1_trig", {31'd0, a_trig}, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t1_vld", {31'd0, a_vld}, 1);
      chk("t1_data", {19'd0, a_rdata}, 17 + i);
      chk("t1_last", {31'd0, a_last}, (i == 7) ? 1 : 0);
      drive(13'(26 + i), 1'b0, 1'b1);
    end
    chk("t1_vld_end", {31'd0, a_vld}, 0);
    chk("t1_done_end", {31'd0, a_done}, 0);
    chk("t1_busy_end", {31'd0, a_busy}, 0);
    chk("t1_trig_end", {31'd0, a_trig}, 1);

    // Test 2: trigger value only seen during PRE, then probe held
    a_tval = 13'd7;
    run_sched(9, 6);
    for (int i = 0; i < 20; i++) drive(13'd9, 1'b0, 1'b0);
    chk("t2_busy", {31'd0, a_busy}, 1);
    chk("t2_done", {31'd0, a_done}, 0);
    chk("t2_trig", {31'd0, a_trig}, 0);

    // Test 3: arm in ARMED restarts; stalled readout from table
    a_tval = 13'd20;
    run_sched(25, 6);
    chk("t3_done", {31'd0, a_done}, 1);
    chk("t3_trig", {31'd0, a_trig}, 1);
    for (int i = 0; i < 16; i++) begin
      chk("t3_vld", {31'd0, a_vld}, {31'd0, tbl[i].vld});
      if (tbl[i].vld) chk("t3_data", {19'd0, a_rdata}, {19'd0, tbl[i].dat});
      chk("t3_last", {31'd0, a_last}, {31'd0, tbl[i].last});
      drive(13'd30, 1'b0, tbl[i].rdy);
    end

    // Test 4: inverted probe, zero mask -> trigger on first ARMED cycle
    b_arm = 1'b1;
    drive(13'd0, 1'b0, 1'b0);
    b_arm = 1'b0;
    for (int i = 0; i < 3; i++) drive(13'd0, 1'b0, 1'b0);
    chk("t4_busy_pre", {31'd0, b_busy}, 1);
    chk("t4_trig_pre", {31'd0, b_trig}, 0);
    drive(13'd0, 1'b0, 1'b0);
    chk("t4_trig_hit", {31'd0, b_trig}, 1);
    for (int i = 0; i < 3; i++) drive(13'd0, 1'b0, 1'b0);
    chk("t4_done_early", {31'd0, b_done}, 0);
    drive(13'd0, 1'b0, 1'b0);
    chk("t4_done", {31'd0, b_done}, 1);
    for (int i = 0; i < 8; i++) begin
      chk("t4_vld", {31'd0, b_vld}, 1);
      chk("t4_data", {19'd0, b_rdata}, 32'h1FFF);
      chk("t4_last", {31'd0, b_last}, (i == 7) ? 1 : 0);
      b_rdy = 1'b1;
      b_arm = (i == 7);
      drive(13'd0, 1'b0, 1'b0);
    end
    b_rdy = 1'b0;
    b_arm = 1'b0;
    chk("t4_rearm_busy", {31'd0, b_busy}, 1);
    chk("t4_rearm_done", {31'd0, b_done}, 0);
    chk("t4_rearm_trig", {31'd0, b_trig}, 0);

    // Test 5: arm in POST, then reset in POST
    run_sched(22, 6);
    chk("t5_trig_post", {31'd0, a_trig}, 1);
    chk("t5_busy_post", {31'd0, a_busy}, 1);
    drive(13'd23, 1'b1, 1'b0);
    chk("t5_rearm_trig", {31'd0, a_trig}, 0);
    chk("t5_rearm_busy", {31'd0, a_busy}, 1);
    chk("t5_rearm_done", {31'd0, a_done}, 0);
    run_sched(22, 6);
    chk("t5_trig2", {31'd0, a_trig}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, a_busy}, 0);
    chk("t5_rst_trig", {31'd0, a_trig}, 0);
    chk("t5_rst_done", {31'd0, a_done}, 0);
    chk("t5_rst_vld", {31'd0, a_vld}, 0);
    chk("t5_rst_last", {31'd0, a_last}, 0);
    chk("t5_rst_bbusy", {31'd0, b_busy}, 0);
    chk("t5_rst_bdone", {31'd0, b_done}, 0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) drive(13'd40, 1'b0, 1'b0);
    chk("t5_idle_busy", {31'd0, a_busy}, 0);
    chk("t5_idle_done", {31'd0, a_done}, 0);

    // Test 6: data pass-through delay
    data_in = 8'hA5;
    drive(13'd0, 1'b0, 1'b0);
    data_in = 8'h00;
    chk("t6_dout_c1", {24'd0, a_data_out}, 0);
    drive(13'd0, 1'b0, 1'b0);
    chk("t6_dout_c2", {24'd0, a_data_out}, 32'hA5);
    drive(13'd0, 1'b0, 1'b0);
    chk("t6_dout_c3", {24'd0, a_data_out}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
